// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin pop arbiter.
//   - Default sizes for NUM_FIFOS / WORD_SIZE.
//   - Position of the destination field (top DEST_W bits of each word).
//   - FSM state encoding and the per-destination push counter width.
package arb_pkg;

    localparam int DEF_NUM_FIFOS = 4;
    localparam int DEF_WORD_SIZE = 10;

    // Destination field occupies word bits [WORD_SIZE-1 : WORD_SIZE-DEST_W]
    localparam int DEST_W = 2;

    // Width of each saturating per-destination push counter (stats build)
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_POP  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant selection.
//   req_i : request vector, one bit per requester
//   ptr_i : index of the highest-priority requester this cycle
//   gnt_o : one-hot grant to the first requester at or after ptr_i (wrapping),
//           all-zero when nothing requests
module rr_grant #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [PW-1:0] idx;
    logic          found;

    // N is a power of two, so ptr_i + k wraps naturally in PW bits
    always_comb begin
        gnt_o = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = ptr_i + PW'(k);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_rr_pop.sv
// Round-robin arbiter that pops upstream FIFOs and pushes each word to the
// downstream FIFO named by the word's destination field.
//
// Ports:
//   clk              : clock, rising edge
//   reset            : asynchronous, active-high reset
//   fifo_empty       : empty flag per upstream FIFO
//   fifo_data        : data_out per upstream FIFO, FIFO 0 in the LSBs
//   out_almost_full  : almost-full flag per downstream FIFO
//   fifo_rd_en       : one-hot pop to the upstream FIFOs
//   out_wr_en        : one-hot push to the downstream FIFOs
//   out_data         : word presented to every downstream FIFO
//   active           : high while the FSM is in POP
//   push_count       : (ARB_RR_STATS_EN only) 8-bit saturating push count per
//                      destination, destination 0 in the LSBs
//
// Build option: define ARB_RR_STATS_EN to add push_count and its counters.
//
// Timing: a pop issued in cycle t is pushed in cycle t+1, with the push
// decoded combinationally from the upstream data_out that is valid then.
module arb_rr_pop
    import arb_pkg::*;
#(
    parameter int NUM_FIFOS = DEF_NUM_FIFOS,
    parameter int WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_FIFOS-1:0]           fifo_empty,
    input  logic [NUM_FIFOS*WORD_SIZE-1:0] fifo_data,
    input  logic [NUM_FIFOS-1:0]           out_almost_full,
    output logic [NUM_FIFOS-1:0]           fifo_rd_en,
    output logic [NUM_FIFOS-1:0]           out_wr_en,
    output logic [WORD_SIZE-1:0]           out_data,
    output logic                           active
`ifdef ARB_RR_STATS_EN
    ,
    output logic [NUM_FIFOS*CNT_W-1:0]     push_count
`endif
);

    localparam int PW = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;

    arb_state_e           state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        sel_q;
    logic [PW-1:0]        gnt_idx;
    logic [NUM_FIFOS-1:0] popped_q;
    logic [NUM_FIFOS-1:0] elig;
    logic [NUM_FIFOS-1:0] gnt;
    logic                 pend_q;
    logic [WORD_SIZE-1:0] data_q;
    logic [WORD_SIZE-1:0] rd_word;
    logic [DEST_W-1:0]    dest;
    logic                 any_af;
    logic                 any_avail;

    // A FIFO popped last cycle may still show a stale non-empty flag, so it
    // sits out one cycle.
    assign elig      = ~fifo_empty & ~popped_q;
    assign any_af    = |out_almost_full;
    assign any_avail = |(~fifo_empty);

    rr_grant #(
        .N  (NUM_FIFOS),
        .PW (PW)
    ) u_grant (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
    end

    // Destination is unknown until the word is popped, so any almost-full
    // downstream FIFO blocks all pops.
    assign fifo_rd_en = (state_q == ST_POP && !any_af) ? gnt : '0;

    // Next state. Leaving POP looks at raw non-empty flags rather than
    // eligibility: a FIFO masked only for its one-cycle lag window keeps POP
    // alive, so a single busy FIFO is popped every other cycle instead of
    // bouncing through IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (|elig && !any_af)     state_d = ST_POP;
            ST_POP:  if (!any_avail || any_af) state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|fifo_rd_en) begin
            ptr_d = (gnt_idx == PW'(NUM_FIFOS - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    // Push side: word popped last cycle is on its FIFO's data_out now.
    assign rd_word = fifo_data[int'(sel_q)*WORD_SIZE +: WORD_SIZE];
    assign dest    = rd_word[WORD_SIZE-1 -: DEST_W];

    always_comb begin
        out_wr_en = '0;
        if (pend_q) begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                if (dest == DEST_W'(i)) out_wr_en[i] = 1'b1;
            end
        end
    end

    assign out_data = pend_q ? rd_word : data_q;
    assign active   = (state_q == ST_POP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            popped_q <= '0;
            pend_q   <= 1'b0;
            sel_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            popped_q <= fifo_rd_en;
            pend_q   <= |fifo_rd_en;
            if (|fifo_rd_en) sel_q  <= gnt_idx;
            if (pend_q)      data_q <= rd_word;
        end
    end

`ifdef ARB_RR_STATS_EN
    logic [NUM_FIFOS-1:0][CNT_W-1:0] cnt_q;

    for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q[g] <= '0;
            end else if (out_wr_en[g] && cnt_q[g] != {CNT_W{1'b1}}) begin
                cnt_q[g] <= cnt_q[g] + CNT_W'(1);
            end
        end
    end

    assign push_count = cnt_q;
`endif

endmodule

// File: tb/tb_arb_rr_pop.sv
// Directed bench for arb_rr_pop with a behavioural upstream FIFO model and a
// push scoreboard: each loaded word queues its expected push, and a monitor
// compares every push the DUT makes against the head of that queue.
module tb_arb_rr_pop;

    localparam int NF = 4;
    localparam int WS = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NF-1:0]    fifo_empty = '1;
    logic [NF*WS-1:0] fifo_data = '0;
    logic [NF-1:0]    out_almost_full = '0;
    logic [NF-1:0]    fifo_rd_en;
    logic [NF-1:0]    out_wr_en;
    logic [WS-1:0]    out_data;
    logic             active;
`ifdef ARB_RR_STATS_EN
    logic [NF*8-1:0]  push_count;
`endif

    always #5 clk = ~clk;

    arb_rr_pop #(.NUM_FIFOS(NF), .WORD_SIZE(WS)) dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty      (fifo_empty),
        .fifo_data       (fifo_data),
        .out_almost_full (out_almost_full),
        .fifo_rd_en      (fifo_rd_en),
        .out_wr_en       (out_wr_en),
        .out_data        (out_data),
        .active          (active)
`ifdef ARB_RR_STATS_EN
        ,
        .push_count      (push_count)
`endif
    );

    logic [WS-1:0] fq [NF][$];
    logic [WS-1:0] dout [NF];
    logic [13:0]   sb [$];
    int errors = 0;
    int checks = 0;
    int pushes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every push must match the next expected word.
    always @(negedge clk) begin
        if (!reset && out_wr_en !== '0) begin
            pushes++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_push: got wr_en=%b data=%h, required no push", out_wr_en, out_data);
            end else begin
                chk("push", {18'b0, out_wr_en, out_data}, {18'b0, sb.pop_front()});
            end
        end
    end

    task automatic update_flags();
        for (int i = 0; i < NF; i++) begin
            fifo_empty[i] = (fq[i].size() == 0);
            fifo_data[i*WS +: WS] = dout[i];
        end
    endtask

    task automatic load(input int f, input logic [WS-1:0] w, input bit expect_push);
        logic [3:0] oh;
        fq[f].push_back(w);
        if (expect_push) begin
            oh = 4'b0001 << w[9:8];
            sb.push_back({oh, w});
        end
        update_flags();
    endtask

    // One clock: sample outputs at the falling edge, then let the FIFO model
    // react to the pop just after the rising edge.
    task automatic tick(output logic [3:0] rd, output logic [3:0] wr);
        @(negedge clk);
        rd = fifo_rd_en;
        wr = out_wr_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < NF; i++) begin
            if (rd[i] && fq[i].size() > 0) dout[i] = fq[i].pop_front();
        end
        update_flags();
    endtask

    task automatic wait_pop(input string name, output logic [3:0] rd);
        logic [3:0] wr;
        rd = '0;
        for (int n = 0; n < 6 && rd == '0; n++) tick(rd, wr);
        if (rd == '0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no fifo_rd_en, required a pop within 6 cycles", name);
        end
    endtask

    task automatic drain(input string name, input int n);
        logic [3:0] rd, wr;
        repeat (n) tick(rd, wr);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        out_almost_full = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] rd, wr;
        logic [3:0] exp_g [5];
        int p0;
        for (int i = 0; i < NF; i++) dout[i] = '0;
        update_flags();

        // Asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #2;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_wr_en", out_wr_en, 0);
        chk("rst_data", out_data, 0);
        chk("rst_active", active, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single word, dest 3: pop at t, push at t+1
        load(0, 10'h301, 1);
        wait_pop("t1", rd);
        chk("t1_rd", rd, 4'b0001);
        tick(rd, wr);
        chk("t1_latency_wr", wr, 4'b1000);
        drain("t1", 6);

        // All FIFOs busy: grants 0,1,2,3,0
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int f = 0; f < NF; f++)
                load(f, {2'((f + k) % 4), 8'(f * 16 + k)}, 1);
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        wait_pop("t2", rd);
        chk("t2_grant0", rd, exp_g[0]);
        for (int k = 1; k < 5; k++) begin
            tick(rd, wr);
            chk("t2_grant", rd, exp_g[k]);
        end
        drain("t2", 12);

        // Only FIFO 2, three words: alternate pops, three pushes
        do_reset();
        p0 = pushes;
        load(2, 10'h155, 1);
        load(2, 10'h2AA, 1);
        load(2, 10'h00F, 1);
        wait_pop("t3", rd);
        chk("t3_pop0", rd, 4'b0100);
        for (int k = 0; k < 4; k++) begin
            tick(rd, wr);
            chk("t3_alt", rd, (k % 2 == 0) ? 4'b0000 : 4'b0100);
        end
        drain("t3", 8);
        chk("t3_push_total", pushes - p0, 3);

        // Backpressure with a word in flight
        do_reset();
        load(0, 10'h1A5, 1);
        load(1, 10'h3C3, 1);
        load(0, 10'h255, 1);
        wait_pop("t4", rd);
        chk("t4_pop0", rd, 4'b0001);
        out_almost_full = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            tick(rd, wr);
            chk("t4_af_no_pop", rd, 0);
            if (k == 0) chk("t4_inflight_push", wr, 4'b0010);
        end
        out_almost_full = '0;
        tick(rd, wr);
        chk("t4_clear_cycle", rd, 0);
        tick(rd, wr);
        chk("t4_resume", rd, 4'b0010);
        drain("t4", 8);

        // Reset between pop and push discards the word
        do_reset();
        load(0, 10'h2C3, 0);
        wait_pop("t5", rd);
        chk("t5_pop", rd, 4'b0001);
        reset = 1'b1;
        #1;
        chk("t5_rst_wr_en", out_wr_en, 0);
        chk("t5_rst_rd_en", fifo_rd_en, 0);
        chk("t5_rst_data", out_data, 0);
        chk("t5_rst_active", active, 0);
        @(negedge clk);
        reset = 1'b0;
        drain("t5", 8);

`ifdef ARB_RR_STATS_EN
        do_reset();
        for (int k = 0; k < 300; k++) load(0, {2'b00, 8'(k)}, 1);
        drain("stats", 650);
        chk("stats_dest0_sat", push_count[7:0], 8'd255);
        chk("stats_dest1", push_count[15:8], 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arb_rr_pop.md
ARB_RR_POP -- requirements
Module: arb_rr_pop

Interface
REQ-001 SHALL have parameter NUM_FIFOS, default 4, number of upstream FIFOs and downstream FIFOs (power of 2).
REQ-002 SHALL have parameter WORD_SIZE, default 10, FIFO word width; bits [WORD_SIZE-1:WORD_SIZE-2] are the destination field.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fifo_empty  input  NUM_FIFOS  empty_flag of each upstream FIFO.
REQ-006 SHALL have port fifo_data  input  NUM_FIFOS*WORD_SIZE  data_out of each upstream FIFO, packed with FIFO 0 in the LSBs.
REQ-007 SHALL have port out_almost_full  input  NUM_FIFOS  almost_full_flag of each downstream FIFO.
REQ-008 SHALL have port fifo_rd_en  output  NUM_FIFOS  one-hot pop to upstream FIFOs.
REQ-009 SHALL have port out_wr_en  output  NUM_FIFOS  one-hot push to downstream FIFOs.
REQ-010 SHALL have port out_data  output  WORD_SIZE  word presented to all downstream FIFOs.
REQ-011 SHALL have port active  output  1  high while the FSM is in POP state.

Function
REQ-012 SHALL implement FSM IDLE/POP: IDLE->POP when any FIFO is eligible and no out_almost_full bit is set; POP->IDLE when none is eligible or any out_almost_full bit is set.
REQ-013 SHALL treat FIFO i as eligible when fifo_empty[i]=0 and FIFO i was not popped in the previous cycle (covers the 1-cycle flag lag).
REQ-014 SHALL, in POP, assert exactly one fifo_rd_en bit per cycle, chosen round-robin starting from the index after the last grant; after reset the priority pointer is 0.
REQ-015 SHALL treat upstream read data as valid one cycle after fifo_rd_en; the captured word goes to out_data and out_wr_en[dest] in that cycle (pop-to-push latency 1 cycle).
REQ-016 SHALL hold fifo_rd_en at all-zero in IDLE and whenever any out_almost_full bit is set (conservative backpressure; destination unknown before pop).
REQ-017 SHALL still complete the push of a word already popped when out_almost_full rises in the same cycle; no popped word is dropped.
REQ-018 SHALL hold out_data at its last value when out_wr_en is zero.
REQ-019 SHALL wrap the round-robin pointer from NUM_FIFOS-1 to 0.

Reset
REQ-020 SHALL drive fifo_rd_en=0, out_wr_en=0, out_data=0, active=0, FSM=IDLE, pointer=0 while reset=1, independent of clk.
REQ-021 SHALL discard any in-flight pop on reset assertion mid-operation, with no push after release.

Configuration
REQ-022 SHALL, with macro ARB_RR_STATS_EN defined, add output push_count (NUM_FIFOS*8), one 8-bit saturating count of pushes per destination, cleared by reset.
REQ-023 SHALL, without ARB_RR_STATS_EN, omit push_count and all counter logic.

Structure
REQ-024 SHALL place NUM_FIFOS/WORD_SIZE defaults, destination-field bit positions and FSM state encodings in shared package arb_pkg.
REQ-025 SHALL place round-robin grant logic in sub-module rr_grant (request vector + pointer in, one-hot grant out).

Verification
REQ-026 SHALL cover: FIFO 0 holds 0x301 (dest 3), others empty -> fifo_rd_en=0001 at cycle t, out_wr_en=1000 with out_data=0x301 at t+1.
REQ-027 SHALL cover: all four FIFOs non-empty -> grants 0,1,2,3,0 on consecutive POP cycles.
REQ-028 SHALL cover: only FIFO 2 non-empty with 3 words -> pops on alternating cycles, 3 pushes in total.
REQ-029 SHALL cover: out_almost_full[1]=1 while words are pending -> no fifo_rd_en; the in-flight word is still pushed; popping resumes the cycle after the flag clears.
REQ-030 SHALL cover: reset asserted between pop and push -> out_wr_en stays 0 and all outputs are 0 asynchronously.
REQ-031 SHALL cover, with ARB_RR_STATS_EN: 300 pushes to dest 0 -> push_count[7:0]=255.
